// File: rtl/fft_unload8.sv
// Ping-pong unload buffer: one parallel 8-point FFT frame in, one sample/cycle out.
// FFT_UNLOAD_BITREV_EN selects natural-order readout; undefined keeps core order.
module fft_unload8 #(
  parameter int DATA_WD = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frm_val_i,
  output logic                   frm_rdy_o,
  input  logic [8*2*DATA_WD-1:0] frm_dat_i,
  output logic                   out_val_o,
  input  logic                   out_rdy_i,
  output logic [DATA_WD-1:0]     out_re_o,
  output logic [DATA_WD-1:0]     out_im_o,
  output logic [2:0]             out_idx_o,
  output logic                   out_last_o
);

  localparam int SW = 2 * DATA_WD;

  logic [SW-1:0] bank_q [2][8];
  logic [1:0]    cnt_q, cnt_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [2:0]    rd_idx_q, rd_idx_d;

  logic          accept;
  logic          xfer;
  logic          rel;
  logic [2:0]    slot;
  logic [SW-1:0] word;

  assign frm_rdy_o = (cnt_q != 2'd2) && !rst;
  assign accept    = frm_val_i && frm_rdy_o;
  assign out_val_o = (cnt_q != 2'd0);
  assign xfer      = out_val_o && out_rdy_i;
  assign rel       = xfer && (rd_idx_q == 3'd7);

`ifdef FFT_UNLOAD_BITREV_EN
  // Core emits bit-reversed order; undo it on readout.
  assign slot = {rd_idx_q[0], rd_idx_q[1], rd_idx_q[2]};
`else
  assign slot = rd_idx_q;
`endif

  assign word       = bank_q[rd_ptr_q][slot];
  assign out_re_o   = word[SW-1:DATA_WD];
  assign out_im_o   = word[DATA_WD-1:0];
  assign out_idx_o  = rd_idx_q;
  assign out_last_o = out_val_o && (rd_idx_q == 3'd7);

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rd_idx_d = rd_idx_q;
    if (accept) wr_ptr_d = ~wr_ptr_q;
    if (xfer)   rd_idx_d = rd_idx_q + 3'd1;
    if (rel)    rd_ptr_d = ~rd_ptr_q;
    unique case ({accept, rel})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rd_idx_q <= '0;
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < 8; s++)
          bank_q[b][s] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_idx_q <= rd_idx_d;
      if (accept)
        for (int s = 0; s < 8; s++)
          bank_q[wr_ptr_q][s] <= frm_dat_i[s*SW +: SW];
    end
  end

endmodule

// File: tb/tb_fft_unload8.sv
// Directed bench for fft_unload8: table-driven single frame plus
// hand-written reset, backpressure, full-buffer and streaming sequences.
module tb_fft_unload8;

  logic         clk = 1'b0;
  logic         rst;
  logic         frm_val_i;
  logic         frm_rdy_o;
  logic [255:0] frm_dat_i;
  logic         out_val_o;
  logic         out_rdy_i;
  logic [15:0]  out_re_o;
  logic [15:0]  out_im_o;
  logic [2:0]   out_idx_o;
  logic         out_last_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fft_unload8 #(.DATA_WD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .frm_val_i (frm_val_i),
    .frm_rdy_o (frm_rdy_o),
    .frm_dat_i (frm_dat_i),
    .out_val_o (out_val_o),
    .out_rdy_i (out_rdy_i),
    .out_re_o  (out_re_o),
    .out_im_o  (out_im_o),
    .out_idx_o (out_idx_o),
    .out_last_o(out_last_o)
  );

  typedef struct {
    logic        fv;
    logic        ordy;
    int          fid;
    logic        ev;
    logic [2:0]  eidx;
    logic [15:0] ere;
    logic [15:0] eim;
    logic        elast;
    logic        efr;
  } vec_t;

  vec_t tbl [9];

  // Frame f: slot s holds re=0x0010+0x100*f+s, im=0x0020+0x100*f+s.
  function automatic logic [255:0] mkframe(int f);
    logic [255:0] d;
    d = '0;
    for (int s = 0; s < 8; s++) begin
      d[s*32+16 +: 16] = 16'(16'h0010 + f * 256 + s);
      d[s*32    +: 16] = 16'(16'h0020 + f * 256 + s);
    end
    return d;
  endfunction

  function automatic logic [2:0] slot_of(int k);
    logic [2:0] kk;
    kk = k[2:0];
`ifdef FFT_UNLOAD_BITREV_EN
    return {kk[0], kk[1], kk[2]};
`else
    return kk;
`endif
  endfunction

  function automatic logic [15:0] exp_re(int f, int k);
    return 16'(16'h0010 + f * 256 + int'(slot_of(k)));
  endfunction

  function automatic logic [15:0] exp_im(int f, int k);
    return 16'(16'h0020 + f * 256 + int'(slot_of(k)));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_smp(string tag, int f, int k);
    chk({tag, "_val"},  32'(out_val_o),  32'd1);
    chk({tag, "_idx"},  32'(out_idx_o),  32'(k));
    chk({tag, "_re"},   32'(out_re_o),   32'(exp_re(f, k)));
    chk({tag, "_im"},   32'(out_im_o),   32'(exp_im(f, k)));
    chk({tag, "_last"}, 32'(out_last_o), 32'(k == 7));
  endtask

  initial begin
    rst       = 1'b1;
    frm_val_i = 1'b1;
    frm_dat_i = mkframe(9);
    out_rdy_i = 1'b1;

    // Reset held 3 cycles with a frame being offered.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_frm_rdy", 32'(frm_rdy_o), 32'd0);
      chk("rst_out_val", 32'(out_val_o), 32'd0);
      chk("rst_out_re",  32'(out_re_o),  32'd0);
      chk("rst_out_idx", 32'(out_idx_o), 32'd0);
    end
    rst       = 1'b0;
    frm_val_i = 1'b0;
    #1;
    chk("rel_frm_rdy", 32'(frm_rdy_o), 32'd1);
    tick();
    chk("rel_out_val", 32'(out_val_o), 32'd0);

    // Single frame, table-driven.
    for (int i = 0; i < 9; i++) begin
      tbl[i].fv    = (i == 0);
      tbl[i].ordy  = 1'b1;
      tbl[i].fid   = 0;
      tbl[i].ev    = (i < 8);
      tbl[i].eidx  = (i < 8) ? 3'(i) : 3'd0;
      tbl[i].ere   = (i < 8) ? exp_re(0, i) : exp_re(0, 0);
      tbl[i].eim   = (i < 8) ? exp_im(0, i) : exp_im(0, 0);
      tbl[i].elast = (i == 7);
      tbl[i].efr   = 1'b1;
    end
    for (int i = 0; i < 9; i++) begin
      frm_val_i = tbl[i].fv;
      frm_dat_i = mkframe(tbl[i].fid);
      out_rdy_i = tbl[i].ordy;
      tick();
      chk("tbl_val",  32'(out_val_o), 32'(tbl[i].ev));
      chk("tbl_frdy", 32'(frm_rdy_o), 32'(tbl[i].efr));
      if (tbl[i].ev) begin
        chk("tbl_idx",  32'(out_idx_o),  32'(tbl[i].eidx));
        chk("tbl_re",   32'(out_re_o),   32'(tbl[i].ere));
        chk("tbl_im",   32'(out_im_o),   32'(tbl[i].eim));
        chk("tbl_last", 32'(out_last_o), 32'(tbl[i].elast));
      end
    end

    // Backpressure: stall 5 cycles at k=3.
    frm_val_i = 1'b1;
    frm_dat_i = mkframe(1);
    out_rdy_i = 1'b1;
    tick();
    frm_val_i = 1'b0;
    chk_smp("bp", 1, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_smp("bp", 1, k);
    end
    out_rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_smp("bp_hold", 1, 3);
    end
    out_rdy_i = 1'b1;
    for (int k = 4; k <= 7; k++) begin
      tick();
      chk_smp("bp", 1, k);
    end
    tick();
    chk("bp_end_val", 32'(out_val_o), 32'd0);

    // Full buffer: A=2, B=3 accepted, C=4 refused until A drains.
    out_rdy_i = 1'b0;
    frm_val_i = 1'b1;
    frm_dat_i = mkframe(2);
    tick();
    chk("full_rdy_a", 32'(frm_rdy_o), 32'd1);
    frm_dat_i = mkframe(3);
    tick();
    chk("full_rdy_b", 32'(frm_rdy_o), 32'd0);
    frm_dat_i = mkframe(4);
    tick();
    chk("full_rdy_c0", 32'(frm_rdy_o), 32'd0);
    tick();
    chk("full_rdy_c1", 32'(frm_rdy_o), 32'd0);
    chk_smp("full_a", 2, 0);
    out_rdy_i = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_smp("full_a", 2, k);
      chk("full_a_frdy", 32'(frm_rdy_o), 32'd0);
    end
    tick();
    chk_smp("full_b", 3, 0);
    chk("full_post_a_frdy", 32'(frm_rdy_o), 32'd1);
    tick();
    frm_val_i = 1'b0;
    chk_smp("full_b", 3, 1);
    chk("full_c_acc_frdy", 32'(frm_rdy_o), 32'd0);
    for (int k = 2; k <= 7; k++) begin
      tick();
      chk_smp("full_b", 3, k);
    end
    tick();
    chk("full_post_b_frdy", 32'(frm_rdy_o), 32'd1);
    for (int k = 0; k <= 7; k++) begin
      chk_smp("full_c", 4, k);
      tick();
    end
    chk("full_end_val", 32'(out_val_o), 32'd0);

    // Streaming: frames 5..8 every 8 cycles, no bubble.
    out_rdy_i = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      frm_val_i = (c % 8 == 0) && (c < 32);
      frm_dat_i = mkframe(5 + c / 8);
      tick();
      if (c < 32) begin
        chk_smp("strm", 5 + c / 8, c % 8);
        chk("strm_frdy", 32'(frm_rdy_o), 32'd1);
      end else begin
        chk("strm_end_val", 32'(out_val_o), 32'd0);
      end
    end

    // Reset mid-frame discards everything.
    frm_val_i = 1'b1;
    frm_dat_i = mkframe(10);
    tick();
    frm_val_i = 1'b0;
    tick();
    chk_smp("mid", 10, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_val", 32'(out_val_o), 32'd0);
    chk("mid_rst_re",  32'(out_re_o),  32'd0);
    chk("mid_rst_idx", 32'(out_idx_o), 32'd0);
    chk("mid_rst_frdy", 32'(frm_rdy_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_unload8.md
Name: fft_unload8

Overview:
- Output-side companion of the 8-point FFT core.
- Captures one parallel 8-point complex result frame, as packed by the core's output bus, into a two-bank ping-pong buffer.
- Streams the frame out one complex sample per cycle under a valid/ready handshake, in natural frequency order.
- Sits between the combinational/pipelined FFT core and the downstream serial consumer (result memory or output port).

Parameters:
- DATA_WD, 16: width of each real or imaginary component of one sample; must equal the FFT core output width.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- frm_val_i  input  1  parallel frame valid from FFT core side
- frm_rdy_o  output  1  buffer can accept a frame
- frm_dat_i  input  8*2*DATA_WD  packed frame; sample s at bits [s*2*DATA_WD +: 2*DATA_WD], real in upper DATA_WD, imag in lower DATA_WD
- out_val_o  output  1  serial sample valid
- out_rdy_i  input  1  downstream ready
- out_re_o  output  DATA_WD  real part of current sample
- out_im_o  output  DATA_WD  imaginary part of current sample
- out_idx_o  output  3  frequency index k of current sample (0..7)
- out_last_o  output  1  high with k==7 (final sample of frame)

Behaviour:
- Storage: two banks of 8 x 2*DATA_WD registers; wr_ptr, rd_ptr (1 bit each); cnt (0..2) frames held; rd_idx (3 bit).
- Reset (rst=1 at an edge):
  - cnt=0, wr_ptr=0, rd_ptr=0, rd_idx=0, all bank registers cleared to 0.
  - Consequence: out_val_o=0, out_re_o=0, out_im_o=0, out_idx_o=0, out_last_o=0.
  - frm_rdy_o is forced 0 while rst is high and reads 1 in the first cycle after reset releases.
  - Reset mid-frame discards both banks; no partial frame is resumed.
- frm_rdy_o = (cnt<2) && !rst; combinational from registered state only, never from out_rdy_i.
- Frame accept (frm_val_i && frm_rdy_o at an edge): the whole frm_dat_i is written to bank[wr_ptr]; wr_ptr toggles. frm_dat_i is ignored when not accepted.
- Output enable: out_val_o = (cnt!=0). All output fields are combinational from bank[rd_ptr] and rd_idx; no combinational path from any input to any output.
- Sample order:
  - out_idx_o = rd_idx.
  - Sample driven = slot bitrev3(rd_idx), e.g. k=1 reads slot 4 and k=3 reads slot 6, because the core emits bit-reversed order.
- Sample transfer (out_val_o && out_rdy_i):
  - Normally rd_idx increments.
  - When rd_idx==7: rd_idx wraps to 0, rd_ptr toggles, and the bank is released.
- Stall: while out_val_o=1 and out_rdy_i=0, all out_* outputs hold stable.
- cnt update: +1 on accept only, -1 on final-sample transfer only, unchanged when both or neither occur in the same cycle.
- Boundaries:
  - Accept and release in the same cycle: legal only when cnt was 1 (cnt<2). cnt stays 1; the newly written bank becomes the read bank next cycle.
  - cnt==2: frm_rdy_o=0 even if the last sample transfers that cycle; there is no same-cycle pass-through. rdy rises the following cycle.
  - cnt==0: out_rdy_i has no effect.
- Latency: frame accepted at edge N with cnt=0 gives k=0 valid in cycle N+1. Sustained throughput is one sample per cycle; back-to-back frames stream with no bubble when a frame is offered every 8 cycles.
- No arithmetic; data passes bit-exact.

Optional Feature:
- FFT_UNLOAD_BITREV_EN
- Defined: natural-order output as described (slot bitrev3(rd_idx)).
- Undefined: slot rd_idx is driven directly (core order preserved). out_idx_o still counts 0..7 and then denotes slot position, not frequency. Handshake and timing are identical.

Test Plan:
- Reset: hold rst 3 cycles with frm_val_i=1 -> frm_rdy_o=0, out_val_o=0, out_re_o=0; after release frm_rdy_o=1, nothing accepted during reset.
- Single frame: slot s re=16'h0010+s, im=16'h0020+s, out_rdy_i=1 -> cycles N+1..N+8 emit re 0010,0014,0012,0016,0011,0015,0013,0017; out_last_o only on 8th; out_val_o=0 at N+9.
- Same frame with macro undefined -> re 0010..0017 in sequence.
- Backpressure: out_rdy_i low for 5 cycles at k=3 -> out_idx_o=3, re=0016 held stable throughout; stream resumes at k=4, no loss or duplication.
- Full buffer: out_rdy_i=0, offer 3 frames -> first two accepted, frm_rdy_o=0 thereafter. Raise out_rdy_i -> frame A fully output, frm_rdy_o=1 the cycle after A's last, frame C accepted then, then B and C output in order.
- Streaming: new frame offered every 8 cycles, out_rdy_i=1 -> out_val_o continuously 1 for 4 frames (32 cycles), cnt never exceeds 2.
